hms_clock_ctrl: RTL and testbench

Fully synchronous mode/setup controller for the HMS digital clock. It replaces gated-clock sequencing with single-cycle clock enables for the second, minute and hour counters. It debounces the three user buttons, runs the CLOCK/SETUP (optional ALARM) mode state machine, and generates the digit blink mask consumed by the display multiplexer. It sits between the button pins and the hms counter/display datapath, all on clk.

---
 rtl/hms_clk_pkg.sv | 47 ++++
 rtl/hms_clock_ctrl_btn_debounce.sv | 34 +++
 rtl/hms_clock_ctrl.sv | 135 +++++++++++++
 tb/tb_hms_clock_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hms_clk_pkg.sv
// Shared encodings and helpers for the HMS clock mode/setup controller.
package hms_clk_pkg;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_SETUP = 2'd1,
    MODE_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC  = 2'd0,
    POS_MIN  = 2'd1,
    POS_HOUR = 2'd2
  } pos_e;

  localparam int MASK_SEC_LSB  = 0;
  localparam int MASK_MIN_LSB  = 2;
  localparam int MASK_HOUR_LSB = 4;

  // Only the selected digit pair blinks, and only while editing.
  function automatic logic [5:0] blink_mask(mode_e m, pos_e p, logic ph);
    logic [5:0] mk;
    mk = '0;
    if (m != MODE_CLOCK) begin
      case (p)
        POS_SEC:  mk[MASK_SEC_LSB  +: 2] = {2{ph}};
        POS_MIN:  mk[MASK_MIN_LSB  +: 2] = {2{ph}};
        default:  mk[MASK_HOUR_LSB +: 2] = {2{ph}};
      endcase
    end
    return mk;
  endfunction

  function automatic pos_e next_pos(mode_e m, pos_e p);
    pos_e n;
    if (m == MODE_ALARM) n = (p == POS_MIN) ? POS_HOUR : POS_MIN;
    else begin
      case (p)
        POS_SEC: n = POS_MIN;
        POS_MIN: n = POS_HOUR;
        default: n = POS_SEC;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/hms_clock_ctrl_btn_debounce.sv
// Button conditioner: 2-flop sync, 2-sample history on the shared sample
// tick, one-cycle press pulse on the debounced released->pressed edge.
module btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  input  logic sample_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic [1:0] hist_q;
  logic       lvl_q;
  logic       press_q;

  // Reset state reads as "held", so a button held through reset must be
  // seen released before it can produce a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      hist_q  <= 2'b00;
      lvl_q   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_n_i};
      if (sample_i) hist_q <= {hist_q[0], sync_q[1]};
      lvl_q   <= (hist_q == 2'b00);
      press_q <= (hist_q == 2'b00) && !lvl_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/hms_clock_ctrl.sv
// HMS clock mode/setup controller: tick dividers, button events, mode FSM,
// counter enables and blink mask. Define HMS_CLOCK_ALARM_EN for ALARM mode.
module hms_clock_ctrl
  import hms_clk_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int SAMPLE_DIV = 500_000,
  parameter int BLINK_DIV  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic       i_sec_at_max,
  input  logic       i_min_at_max,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_alm_min_inc,
  output logic       o_alm_hour_inc,
  output logic [5:0] o_blink_mask
);

  localparam int HZW = $clog2(CLK_HZ);
  localparam int SMW = $clog2(SAMPLE_DIV);
  localparam int BLW = $clog2(BLINK_DIV);

  logic [HZW-1:0] hz_cnt_q;
  logic [SMW-1:0] sm_cnt_q;
  logic [BLW-1:0] bl_cnt_q;
  logic           hz_tick_q, sm_tick_q, phase_q;
  logic           ev0, ev1, ev2;
  mode_e          mode_q;
  pos_e           pos_q;
  logic           sec_inc_q, min_inc_q, hour_inc_q, alm_min_q, alm_hour_q;
  logic [5:0]     mask_q;

  // Free-running dividers; the 1 Hz one keeps counting in SETUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_cnt_q  <= '0;
      sm_cnt_q  <= '0;
      hz_tick_q <= 1'b0;
      sm_tick_q <= 1'b0;
    end else begin
      hz_tick_q <= (hz_cnt_q == HZW'(CLK_HZ - 1));
      hz_cnt_q  <= (hz_cnt_q == HZW'(CLK_HZ - 1)) ? '0 : hz_cnt_q + HZW'(1);
      sm_tick_q <= (sm_cnt_q == SMW'(SAMPLE_DIV - 1));
      sm_cnt_q  <= (sm_cnt_q == SMW'(SAMPLE_DIV - 1)) ? '0 : sm_cnt_q + SMW'(1);
    end
  end

  btn_debounce u_db0 (.clk(clk), .rst_n(rst_n), .btn_n_i(i_sw0), .sample_i(sm_tick_q), .press_o(ev0));
  btn_debounce u_db1 (.clk(clk), .rst_n(rst_n), .btn_n_i(i_sw1), .sample_i(sm_tick_q), .press_o(ev1));
  btn_debounce u_db2 (.clk(clk), .rst_n(rst_n), .btn_n_i(i_sw2), .sample_i(sm_tick_q), .press_o(ev2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_CLOCK;
      pos_q      <= POS_SEC;
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hour_inc_q <= 1'b0;
      alm_min_q  <= 1'b0;
      alm_hour_q <= 1'b0;
      bl_cnt_q   <= '0;
      phase_q    <= 1'b0;
      mask_q     <= '0;
    end else begin
      sec_inc_q  <= 1'b0;
      min_inc_q  <= 1'b0;
      hour_inc_q <= 1'b0;
      alm_min_q  <= 1'b0;
      alm_hour_q <= 1'b0;

      // Time tick decisions use the mode held before any event this cycle.
      if (hz_tick_q && mode_q != MODE_SETUP) begin
        sec_inc_q  <= 1'b1;
        min_inc_q  <= i_sec_at_max;
        hour_inc_q <= i_sec_at_max & i_min_at_max;
      end

      if (ev0) begin
        case (mode_q)
          MODE_CLOCK: begin mode_q <= MODE_SETUP; pos_q <= POS_SEC; end
`ifdef HMS_CLOCK_ALARM_EN
          MODE_SETUP: begin mode_q <= MODE_ALARM; pos_q <= POS_MIN; end
`endif
          default:    begin mode_q <= MODE_CLOCK; pos_q <= POS_SEC; end
        endcase
      end else if (mode_q != MODE_CLOCK) begin
        // Increment targets the position held before a same-cycle sw1 advance.
        if (ev2) begin
          if (mode_q == MODE_SETUP) begin
            case (pos_q)
              POS_SEC: sec_inc_q  <= 1'b1;
              POS_MIN: min_inc_q  <= 1'b1;
              default: hour_inc_q <= 1'b1;
            endcase
          end
`ifdef HMS_CLOCK_ALARM_EN
          else if (pos_q == POS_HOUR) alm_hour_q <= 1'b1;
          else                        alm_min_q  <= 1'b1;
`endif
        end
        if (ev1) pos_q <= next_pos(mode_q, pos_q);
      end

      if (ev0 || ev1 || ev2) begin
        bl_cnt_q <= '0;
        phase_q  <= 1'b0;
      end else if (bl_cnt_q == BLW'(BLINK_DIV - 1)) begin
        bl_cnt_q <= '0;
        phase_q  <= !phase_q;
      end else begin
        bl_cnt_q <= bl_cnt_q + BLW'(1);
      end

      mask_q <= blink_mask(mode_q, pos_q, phase_q);
    end
  end

  assign o_mode         = mode_q;
  assign o_position     = pos_q;
  assign o_sec_inc      = sec_inc_q;
  assign o_min_inc      = min_inc_q;
  assign o_hour_inc     = hour_inc_q;
  assign o_alm_min_inc  = alm_min_q;
  assign o_alm_hour_inc = alm_hour_q;
  assign o_blink_mask   = mask_q;

endmodule

// File: tb/tb_hms_clock_ctrl.sv
// Directed bench for hms_clock_ctrl with small dividers (100/4/8).
module tb_hms_clock_ctrl;

  localparam int CLK_HZ = 100, SAMPLE_DIV = 4, BLINK_DIV = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic sw0 = 1'b1, sw1 = 1'b1, sw2 = 1'b1, sec_max = 1'b0, min_max = 1'b0;
  logic [1:0] mode, pos;
  logic sec_inc, min_inc, hour_inc, amin_inc, ahour_inc;
  logic [5:0] mask;

  hms_clock_ctrl #(.CLK_HZ(CLK_HZ), .SAMPLE_DIV(SAMPLE_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .i_sw0(sw0), .i_sw1(sw1), .i_sw2(sw2),
    .i_sec_at_max(sec_max), .i_min_at_max(min_max),
    .o_mode(mode), .o_position(pos), .o_sec_inc(sec_inc), .o_min_inc(min_inc),
    .o_hour_inc(hour_inc), .o_alm_min_inc(amin_inc), .o_alm_hour_inc(ahour_inc),
    .o_blink_mask(mask)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int n_sec = 0, n_min = 0, n_hour = 0, n_amin = 0, n_ahour = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    n_sec   += int'(sec_inc);
    n_min   += int'(min_inc);
    n_hour  += int'(hour_inc);
    n_amin  += int'(amin_inc);
    n_ahour += int'(ahour_inc);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic sec_max;
    logic min_max;
    int   exp_min;
    int   exp_hour;
  } tvec_t;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // m selects buttons held together: bit0 sw0, bit1 sw1, bit2 sw2.
  task automatic press(input logic [2:0] m);
    sw0 = !m[0]; sw1 = !m[1]; sw2 = !m[2];
    step(20);
    sw0 = 1'b1; sw1 = 1'b1; sw2 = 1'b1;
    step(20);
  endtask

  initial begin
    tvec_t tv [4];
    int pulses, got, s0, m0, h0, a0, b0, t0, t1;
    logic [1:0] prev;

    tv[0] = '{1'b0, 1'b0, 0, 0};
    tv[1] = '{1'b1, 1'b0, 1, 0};
    tv[2] = '{1'b0, 1'b1, 0, 0};
    tv[3] = '{1'b1, 1'b1, 1, 1};

    step(3);
    chk("reset_mode", mode, 0);
    chk("reset_pos", pos, 0);
    chk("reset_mask", mask, 0);
    chk("reset_sec_inc", sec_inc, 0);

    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 305; c++) begin
      @(posedge clk); #1;
      if (c == 101 || c == 201 || c == 301) chk($sformatf("sec_tick_%0d", c), sec_inc, 1);
      else pulses += int'(sec_inc);
    end
    chk("sec_tick_stray", pulses, 0);
    chk("idle_mode", mode, 0);
    chk("idle_mask", mask, 0);

    for (int i = 0; i < 4; i++) begin
      sec_max = tv[i].sec_max;
      min_max = tv[i].min_max;
      got = 0;
      for (int k = 0; k < 150 && got == 0; k++) begin
        step(1);
        if (sec_inc) got = 1;
      end
      chk($sformatf("vec%0d_tick_seen", i), got, 1);
      chk($sformatf("vec%0d_min_inc", i), min_inc, tv[i].exp_min);
      chk($sformatf("vec%0d_hour_inc", i), hour_inc, tv[i].exp_hour);
    end
    sec_max = 1'b0; min_max = 1'b0;
    step(1);

    for (int g = 0; g < 3; g++) begin
      sw0 = 1'b0; step(2);
      sw0 = 1'b1; step(10);
    end
    step(20);
    chk("glitch_mode", mode, 0);

    press(3'b001);
    chk("setup_mode", mode, 1);
    chk("setup_pos", pos, 0);
    chk("setup_mask_other", int'(mask[5:2]), 0);
    s0 = n_sec;
    step(250);
    chk("setup_frozen_sec", n_sec - s0, 0);

    press(3'b010);
    chk("setup_pos_min", pos, 1);
    s0 = n_sec; m0 = n_min; h0 = n_hour;
    for (int p = 0; p < 3; p++) press(3'b100);
    chk("setup_min_pulses", n_min - m0, 3);
    chk("setup_hour_pulses", n_hour - h0, 0);
    chk("setup_sec_pulses", n_sec - s0, 0);
    chk("setup_pos_kept", pos, 1);

    prev = mask[3:2];
    got = 0;
    for (int k = 0; k < 40 && got == 0; k++) begin
      step(1);
      if (mask[3:2] != prev) got = 1;
    end
    t0 = cyc;
    prev = mask[3:2];
    for (int k = 0; k < 40 && got == 1; k++) begin
      step(1);
      if (mask[3:2] != prev) got = 2;
    end
    t1 = cyc;
    chk("blink_edges_seen", got, 2);
    chk("blink_period", t1 - t0, 8);
    chk("blink_pair_equal", int'(mask[3]), int'(mask[2]));
    chk("blink_other_bits", int'({mask[5:4], mask[1:0]}), 0);

    m0 = n_min; h0 = n_hour; s0 = n_sec; a0 = n_amin; b0 = n_ahour;
    press(3'b101);
    chk("simul_min_pulses", n_min - m0, 0);
    chk("simul_hour_pulses", n_hour - h0, 0);
    chk("simul_alm_pulses", (n_amin - a0) + (n_ahour - b0), 0);
`ifdef HMS_CLOCK_ALARM_EN
    chk("simul_sec_pulses", n_sec - s0, 0);
    chk("alarm_mode", mode, 2);
    chk("alarm_pos", pos, 1);
    s0 = n_sec;
    step(110);
    chk("alarm_time_runs", (n_sec - s0 > 0) ? 1 : 0, 1);
    m0 = n_min; a0 = n_amin;
    press(3'b100);
    chk("alarm_min_pulse", n_amin - a0, 1);
    chk("alarm_no_time_min", n_min - m0, 0);
    press(3'b010);
    chk("alarm_pos_hour", pos, 2);
    b0 = n_ahour;
    press(3'b100);
    chk("alarm_hour_pulse", n_ahour - b0, 1);
    press(3'b001);
    chk("alarm_back_clock", mode, 0);
`else
    chk("simul_mode", mode, 0);
    chk("simul_pos", pos, 0);
    press(3'b001);
    chk("cycle_to_setup", mode, 1);
    press(3'b001);
    chk("cycle_to_clock", mode, 0);
    chk("no_alm_min_total", n_amin, 0);
    chk("no_alm_hour_total", n_ahour, 0);
`endif

    sw0 = 1'b0;
    step(20);
    rst_n = 1'b0;
    step(3);
    chk("midpress_reset_mode", mode, 0);
    @(negedge clk) rst_n = 1'b1;
    step(40);
    chk("midpress_no_event", mode, 0);
    sw0 = 1'b1;
    step(20);
    press(3'b001);
    chk("midpress_repress", mode, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
